// File: rtl/noc_stream_pkg.sv
// Shared types and width helpers for the NoC stream FIFOs (axis_fifo_pkt, sdp_ram).
package noc_stream_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DEPTH      = 8;

  // Default-width beat as stored in the FIFO: payload plus end-of-packet marker.
  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] data;
    logic                      last;
  } entry_t;

  // Bits needed to hold an occupancy of 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Bits needed to address depth entries (at least one bit).
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Width of one stored beat for a given payload width.
  function automatic int entry_width(input int data_width);
    return data_width + 1;
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port storage: one write port, one read port with registered read data.
// A read of the address being written in the same cycle returns the new word.
module sdp_ram
  import noc_stream_pkg::*;
#(
  parameter int WIDTH = 33,
  parameter int DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en_i,
  input  logic [addr_width(DEPTH)-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]            wr_data_i,
  input  logic                        rd_en_i,
  input  logic [addr_width(DEPTH)-1:0] rd_addr_i,
  output logic [WIDTH-1:0]            rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Storage array write; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Registered read with write-first bypass so a beat is visible one cycle after it is written.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
        rd_data_q <= wr_data_i;
      end else begin
        rd_data_q <= mem_q[rd_addr_i];
      end
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/axis_fifo_pkt.sv
// Parametrised AXI-Stream FIFO with occupancy flags and TLAST carry.
// Optional store-and-forward packet mode enabled by defining AXIS_FIFO_PKT_MODE_EN.
// The read-side head beat is the registered output of sdp_ram, addressed by the
// next read pointer, so s_tdata/s_tlast are registers and hold while stalled.
module axis_fifo_pkt
  import noc_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int AFULL_TH   = 6,
  parameter int AEMPTY_TH  = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         m_tdata,
  input  logic                          m_tlast,
  input  logic                          m_tvalid,
  output logic                          m_tready,
  output logic [DATA_WIDTH-1:0]         s_tdata,
  output logic                          s_tlast,
  output logic                          s_tvalid,
  input  logic                          s_tready,
  output logic [count_width(DEPTH)-1:0] count,
  output logic                          almost_full,
  output logic                          almost_empty
);

  localparam int AW = addr_width(DEPTH);
  localparam int CW = count_width(DEPTH);
  localparam int EW = entry_width(DATA_WIDTH);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
  } beat_t;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          m_tready_q, m_tready_d;
  logic          s_tvalid_q, s_tvalid_d;
  logic          afull_q, afull_d;
  logic          aempty_q, aempty_d;
  logic          wr_fire_s, rd_fire_s;
  logic          rd_en_s;
  beat_t         wr_beat_s, rd_beat_s;
  logic [EW-1:0] rd_word_s;

  assign wr_fire_s = m_tvalid && m_tready_q;
  assign rd_fire_s = s_tvalid_q && s_tready;
  assign wr_beat_s = '{data: m_tdata, last: m_tlast};
  assign rd_beat_s = beat_t'(rd_word_s);
  // Only refresh the head register while something will be stored, so it holds its reset value when idle.
  assign rd_en_s   = (count_d != {CW{1'b0}});

  sdp_ram #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_fire_s),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (wr_beat_s),
    .rd_en_i   (rd_en_s),
    .rd_addr_i (rd_ptr_d),
    .rd_data_o (rd_word_s)
  );

  // Pointer and occupancy next state; full/empty come from the count, never from pointer compare.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_fire_s) begin
      wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_fire_s) begin
      rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_fire_s, rd_fire_s})
      2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
  end

  // Flags are functions of the next count so they line up with the registered count.
  always_comb begin
    m_tready_d = (count_d != CW'(DEPTH));
    afull_d    = (count_d >= CW'(AFULL_TH));
    aempty_d   = (count_d <= CW'(AEMPTY_TH));
  end

`ifdef AXIS_FIFO_PKT_MODE_EN
  logic [CW-1:0] pkt_cnt_q, pkt_cnt_d;
  logic          pkt_rel_q, pkt_rel_d;

  // Complete-packet count and oversize-release tracking for store-and-forward.
  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    pkt_rel_d = pkt_rel_q;
    case ({wr_fire_s && m_tlast, rd_fire_s && rd_beat_s.last})
      2'b10:   pkt_cnt_d = pkt_cnt_q + {{(CW-1){1'b0}}, 1'b1};
      2'b01:   pkt_cnt_d = pkt_cnt_q - {{(CW-1){1'b0}}, 1'b1};
      default: pkt_cnt_d = pkt_cnt_q;
    endcase
    // A full FIFO holding no complete packet can never finish one: let it drain cut-through.
    if (rd_fire_s && rd_beat_s.last) begin
      pkt_rel_d = 1'b0;
    end else if ((count_d == CW'(DEPTH)) && (pkt_cnt_d == {CW{1'b0}})) begin
      pkt_rel_d = 1'b1;
    end else begin
      pkt_rel_d = pkt_rel_q;
    end
    s_tvalid_d = (count_d != {CW{1'b0}}) && ((pkt_cnt_d != {CW{1'b0}}) || pkt_rel_d);
  end

  // Packet-mode state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt_q <= {CW{1'b0}};
      pkt_rel_q <= 1'b0;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
      pkt_rel_q <= pkt_rel_d;
    end
  end
`else
  // Cut-through: the head beat is offered as soon as anything is stored.
  always_comb begin
    s_tvalid_d = (count_d != {CW{1'b0}});
  end
`endif

  // Control and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      count_q    <= {CW{1'b0}};
      m_tready_q <= 1'b1;
      s_tvalid_q <= 1'b0;
      afull_q    <= 1'b0;
      aempty_q   <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      m_tready_q <= m_tready_d;
      s_tvalid_q <= s_tvalid_d;
      afull_q    <= afull_d;
      aempty_q   <= aempty_d;
    end
  end

  assign m_tready     = m_tready_q;
  assign s_tvalid     = s_tvalid_q;
  assign s_tdata      = rd_beat_s.data;
  assign s_tlast      = rd_beat_s.last;
  assign count        = count_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;

endmodule

// File: tb/tb_axis_fifo_pkt.sv
// Self-checking bench for axis_fifo_pkt: directed scenarios plus randomized traffic
// against a queue-based reference model. Build with +define+AXIS_FIFO_PKT_MODE_EN for packet mode.
module tb_axis_fifo_pkt;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int AF_TH = 6;
  localparam int AE_TH = 2;
`ifdef AXIS_FIFO_PKT_MODE_EN
  localparam logic PKT = 1'b1;
`else
  localparam logic PKT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] m_tdata;
  logic          m_tlast;
  logic          m_tvalid;
  logic          m_tready;
  logic [DW-1:0] s_tdata;
  logic          s_tlast;
  logic          s_tvalid;
  logic          s_tready;
  logic [3:0]    count;
  logic          almost_full;
  logic          almost_empty;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: queue of {last, data}, plus the oversize-release flag.
  logic [DW:0] mq[$];
  logic        rel_m = 1'b0;

  always #5 clk = ~clk;

  axis_fifo_pkt #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AFULL_TH   (AF_TH),
    .AEMPTY_TH  (AE_TH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .m_tdata      (m_tdata),
    .m_tlast      (m_tlast),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .s_tdata      (s_tdata),
    .s_tlast      (s_tlast),
    .s_tvalid     (s_tvalid),
    .s_tready     (s_tready),
    .count        (count),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic has_last();
    foreach (mq[i]) if (mq[i][DW]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic exp_valid();
    if (mq.size() == 0) return 1'b0;
    if (PKT) return has_last() || rel_m;
    return 1'b1;
  endfunction

  task automatic check_outputs();
    check_eq("m_tready", m_tready, (mq.size() != DEPTH));
    check_eq("s_tvalid", s_tvalid, exp_valid());
    check_eq("count", count, mq.size());
    check_eq("almost_full", almost_full, (mq.size() >= AF_TH));
    check_eq("almost_empty", almost_empty, (mq.size() <= AE_TH));
    if (exp_valid()) begin
      check_eq("s_tdata", s_tdata, mq[0][DW-1:0]);
      check_eq("s_tlast", s_tlast, mq[0][DW]);
    end
  endtask

  // One clock: drive inputs, advance the model on the edge, compare just after it.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic l, input logic r,
                      output logic wr_acc, output logic rd_acc);
    logic          stall;
    logic [DW-1:0] held_d;
    logic          held_l;
    m_tvalid = v;
    m_tdata  = d;
    m_tlast  = l;
    s_tready = r;
    stall  = s_tvalid && !r;
    held_d = s_tdata;
    held_l = s_tlast;
    wr_acc = v && (mq.size() != DEPTH);
    rd_acc = exp_valid() && r;
    @(posedge clk);
    if (rd_acc) begin
      if (mq[0][DW]) rel_m = 1'b0;
      mq.delete(0);
    end
    if (wr_acc) mq.push_back({l, d});
    if ((mq.size() == DEPTH) && !has_last()) rel_m = 1'b1;
    #1;
    check_outputs();
    if (stall) begin
      check_eq("hold_tdata", s_tdata, held_d);
      check_eq("hold_tlast", s_tlast, held_l);
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    m_tvalid = 1'b0;
    m_tdata  = '0;
    m_tlast  = 1'b0;
    s_tready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mq.delete();
    rel_m = 1'b0;
    check_outputs();
    check_eq("rst_s_tdata", s_tdata, 0);
    check_eq("rst_s_tlast", s_tlast, 0);
    rst = 1'b0;
  endtask

  // Close any open packet, then read until the model is empty (bounded).
  task automatic flush();
    logic wa, ra;
    int   n;
    n  = 0;
    wa = 1'b0;
    if (mq.size() != 0 && !mq[mq.size()-1][DW]) begin
      while (!wa && n < 50) begin
        step(1'b1, 32'hF1F1_0000, 1'b1, 1'b1, wa, ra);
        n++;
      end
    end
    n = 0;
    while (mq.size() != 0 && n < 50) begin
      step(1'b0, 32'h0, 1'b0, 1'b1, wa, ra);
      n++;
    end
    check_eq("flush_empty", count, 0);
  endtask

  initial begin
    logic          wa, ra;
    logic          pv, pl;
    logic [DW-1:0] pd;
    int            sent, got;

    // 1: reset
    do_reset();
    check_eq("reset_m_tready", m_tready, 1);
    check_eq("reset_count", count, 0);

    // 2: fill 1..8 with reads stalled, then drain in order
    for (int i = 1; i <= DEPTH; i++) step(1'b1, DW'(i), (i == DEPTH), 1'b0, wa, ra);
    check_eq("fill_count", count, 8);
    check_eq("fill_m_tready", m_tready, 0);
    check_eq("fill_afull", almost_full, 1);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 32'h0, 1'b0, 1'b1, wa, ra);
    check_eq("drain_count", count, 0);
    check_eq("drain_aempty", almost_empty, 1);

    // 3: streaming across pointer wrap, then random read stalls
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 32'h100 + DW'(i), 1'b1, 1'b1, wa, ra);
      check_eq("wrap_count_le1", (count <= 4'd1), 1);
    end
    sent = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 32'h300 + DW'(sent), 1'b1, ($urandom_range(0, 2) == 0), wa, ra);
      if (wa) sent++;
    end
    flush();

    // 4: full FIFO with read and write requested: only the read fires
    for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h400 + DW'(i), (i == DEPTH-1), 1'b0, wa, ra);
    check_eq("full_count", count, 8);
    step(1'b1, 32'h4FF, 1'b1, 1'b1, wa, ra);
    check_eq("full_rw_count", count, 7);
    flush();

    // 5: three-beat packet, last on the third
    step(1'b1, 32'h501, 1'b0, 1'b0, wa, ra);
    check_eq("pkt_valid_after_1st", s_tvalid, !PKT);
    step(1'b1, 32'h502, 1'b0, 1'b0, wa, ra);
    check_eq("pkt_valid_after_2nd", s_tvalid, !PKT);
    step(1'b1, 32'h503, 1'b1, 1'b0, wa, ra);
    check_eq("pkt_valid_after_3rd", s_tvalid, 1);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 1'b1, wa, ra);
    check_eq("pkt3_drained", count, 0);

`ifdef AXIS_FIFO_PKT_MODE_EN
    // 6: ten-beat packet into an eight-entry FIFO
    for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h600 + DW'(i), 1'b0, 1'b0, wa, ra);
    check_eq("oversize_count", count, 8);
    check_eq("oversize_release_valid", s_tvalid, 1);
    sent = DEPTH;
    got  = 0;
    for (int i = 0; i < 40 && got < 10; i++) begin
      step((sent < 10), 32'h600 + DW'(sent), (sent == 9), 1'b1, wa, ra);
      if (wa) sent++;
      if (ra) got++;
    end
    check_eq("oversize_drained", count, 0);
    step(1'b1, 32'h6AA, 1'b0, 1'b0, wa, ra);
    check_eq("release_cleared", s_tvalid, 0);
    flush();
`endif

    // Randomized traffic with a mid-run reset
    pv = 1'b0;
    pd = '0;
    pl = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (c == 900) begin
        do_reset();
        pv = 1'b0;
      end
      if (!pv && $urandom_range(0, 3) != 0) begin
        pv = 1'b1;
        pd = $urandom;
        pl = ($urandom_range(0, 3) == 0);
      end
      step(pv, pd, pl, (c < 1000) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0), wa, ra);
      if (wa) pv = 1'b0;
    end
    flush();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
